shift_reg_n: RTL



---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/shift_reg_n_dff_en.sv | 24 ++
 rtl/shift_reg_n.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_n block: the operation encoding and the
// helper that sizes the fill counter.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    SHIFT_FWD = 2'd1,
    SHIFT_BWD = 2'd2,
    LOAD      = 2'd3
  } mode_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_reg_n_dff_en.sv
// One WIDTH-bit storage cell with clock enable and synchronous reset to zero.
module dff_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised bidirectional shift register with parallel load, tap output
// and a saturating fill counter.
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic [DEPTH*WIDTH-1:0]     load_data,
  input  logic [$clog2(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]           q_fwd,
  output logic [WIDTH-1:0]           q_bwd,
  output logic [WIDTH-1:0]           q_tap,
  output logic [DEPTH*WIDTH-1:0]     q_all,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full
);

  localparam int TAP_W  = $clog2(DEPTH);
  localparam int FILL_W = fill_width(DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] fwd_src;
    logic [WIDTH-1:0] bwd_src;
    logic [WIDTH-1:0] stage_d;

    // End stages take the serial input; inner stages take their neighbour.
    if (gi == 0) begin : g_fwd_head
      assign fwd_src = d;
    end else begin : g_fwd_mid
      assign fwd_src = stage_q[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_bwd_head
      assign bwd_src = d;
    end else begin : g_bwd_mid
      assign bwd_src = stage_q[gi+1];
    end

    always_comb begin
      stage_d = stage_q[gi];
      case (mode_e)
        SHIFT_FWD: stage_d = fwd_src;
        SHIFT_BWD: stage_d = bwd_src;
        LOAD:      stage_d = load_data[gi*WIDTH +: WIDTH];
        default:   stage_d = stage_q[gi];
      endcase
    end

    dff_en #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (stage_d),
      .q     (stage_q[gi])
    );

    assign q_all[gi*WIDTH +: WIDTH] = stage_q[gi];
  end

  assign q_fwd = stage_q[DEPTH-1];
  assign q_bwd = stage_q[0];

  logic [FILL_W-1:0] fill_d, fill_q;
  logic              full_d, full_q;

  always_comb begin
    fill_d = fill_q;
    if (en) begin
      case (mode_e)
        SHIFT_FWD, SHIFT_BWD: if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        LOAD:                 fill_d = FILL_MAX;
        default:              fill_d = fill_q;
      endcase
    end
    full_d = (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign fill = fill_q;
  assign full = full_q;

  // Out-of-range selects (non power-of-2 DEPTH) match no stage and read 0.
  always_comb begin
    q_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) q_tap = stage_q[i];
    end
  end

endmodule
